// File: rtl/cache_refill_arb_pkg.sv
// rtl/cache_refill_arb_pkg.sv - shared types and constants for the cache refill arbiter
// Purpose: FSM state enum, grant encodings, default line width / memory latency,
//          and the line-alignment helper used when latching a miss address.
// Ports:   none (package).
package cache_refill_arb_pkg;

  localparam int LINE_W          = 512;
  localparam int DEFAULT_LATENCY = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Refills are whole 64-byte lines, so the byte offset is dropped.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:6], 6'b0};
  endfunction

endpackage

// File: rtl/cache_refill_arb_if.sv
// rtl/cache_refill_arb_if.sv - cache miss / memory refill bundle
// Purpose: groups the I/D miss requests, the memory read port and the shared
//          refill line return into one bundle.
// Ports:   master - cache/memory side: drives i_req/i_addr, d_req/d_addr, mem_rdata
//          slave  - arbiter side: drives mem_req, mem_addr, line_out, i_ready,
//                   d_ready, busy
interface cache_refill_arb_if #(
  parameter int LINE_W = cache_refill_arb_pkg::LINE_W
);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              d_req;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] line_out;
  logic              i_ready;
  logic              d_ready;
  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_addr, mem_rdata,
    input  mem_req, mem_addr, line_out, i_ready, d_ready, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr, mem_rdata,
    output mem_req, mem_addr, line_out, i_ready, d_ready, busy
  );

endinterface

// File: rtl/cache_refill_arb_rr_arb2.sv
// rtl/cache_refill_arb_rr_arb2.sv - two-input round-robin grant with last-served register
// Purpose: picks I or D for the next refill; on a tie the requester not served
//          last wins. last-served only moves when a refill actually completes.
// Ports:   clk, rst    - clock, async active-high reset
//          i_req_i     - I-cache request
//          d_req_i     - D-cache request
//          update_i    - a refill was delivered this cycle
//          served_i    - which requester that delivered refill belonged to
//          valid_o     - at least one request is pending
//          grant_o     - requester to grant now
module rr_arb2
  import cache_refill_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  logic   update_i,
  input  grant_t served_i,
  output logic   valid_o,
  output grant_t grant_o
);

  grant_t last_q, last_d;

  // Resetting to D makes I win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GRANT_D;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = served_i;
    end
  end

  always_comb begin
    valid_o = i_req_i | d_req_i;
    grant_o = GRANT_I;
    if (i_req_i && d_req_i) begin
      grant_o = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req_i) begin
      grant_o = GRANT_D;
    end
  end

endmodule

// File: rtl/cache_refill_arb.sv
// rtl/cache_refill_arb.sv - I/D cache refill arbiter sharing one memory read port
// Purpose: grants one cache miss at a time, holds mem_req for LATENCY cycles,
//          captures the returned line and pulses the granted cache's ready.
// Ports:   clk  - clock, all state on posedge
//          rst  - async active-high reset
//          bus  - slave side of cache_refill_arb_if (requests, memory port,
//                 line_out, i_ready/d_ready pulses, busy)
module cache_refill_arb #(
  parameter int LATENCY = cache_refill_arb_pkg::DEFAULT_LATENCY,
  parameter int LINE_W  = cache_refill_arb_pkg::LINE_W
) (
  input logic              clk,
  input logic              rst,
  cache_refill_arb_if.slave bus
);

  import cache_refill_arb_pkg::*;

  localparam int              CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  grant_t            grant_q, grant_d;

  logic   arb_valid;
  grant_t arb_grant;
  logic   delivered;
  logic   granted_req;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req_i  (bus.i_req),
    .d_req_i  (bus.d_req),
    .update_i (delivered),
    .served_i (grant_q),
    .valid_o  (arb_valid),
    .grant_o  (arb_grant)
  );

  // The owner of the current refill; the other request is not looked at
  // again until the FSM is back in IDLE.
  assign granted_req = (grant_q == GRANT_I) ? bus.i_req : bus.d_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      grant_q <= GRANT_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    line_d    = line_q;
    grant_d   = grant_q;
    delivered = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          addr_d  = line_align((arb_grant == GRANT_I) ? bus.i_addr : bus.d_addr);
          cnt_d   = CNT_LOAD;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // A withdrawn miss abandons the fetch silently: no capture, no ready,
        // and last-served stays where it was.
        if (!granted_req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          line_d  = bus.mem_rdata;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DELIVER: begin
        delivered = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req  = (state_q == FETCH);
  assign bus.busy     = (state_q != IDLE);
  assign bus.i_ready  = (state_q == DELIVER) && (grant_q == GRANT_I);
  assign bus.d_ready  = (state_q == DELIVER) && (grant_q == GRANT_D);
  assign bus.mem_addr = addr_q;
  assign bus.line_out = line_q;

endmodule
